// File: rtl/image_proc_pkg.sv
// Shared pixel types, BT.601 luma weights and the luma multiply helper.
package image_proc_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned LUMA_COEF_R = 77;
  localparam int unsigned LUMA_COEF_G = 150;
  localparam int unsigned LUMA_COEF_B = 29;
  localparam int unsigned LUMA_ROUND  = 128;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned LUMA_W = 8;

  // 8-bit channel times a Q0.8 weight; the largest product (255*150) fits in 16 bits
  function automatic logic [PROD_W-1:0] luma_mul(input logic [7:0] chan, input int unsigned coef);
    return PROD_W'(chan) * PROD_W'(coef);
  endfunction

endpackage

// File: rtl/axis_rgb2gray_if.sv
// AXI-Stream bundle shared by the RGB input and grayscale output of axis_rgb2gray.
interface axis_rgb2gray_if #(
  parameter int unsigned TDATA_WIDTH_P = 32,
  parameter int unsigned TID_WIDTH_P   = 1,
  parameter int unsigned TDEST_WIDTH_P = 1,
  parameter int unsigned TUSER_WIDTH_P = 1
);
  localparam int unsigned KEEP_W = TDATA_WIDTH_P / 8;

  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH_P-1:0] tdata;
  logic [KEEP_W-1:0]        tkeep;
  logic [KEEP_W-1:0]        tstrb;
  logic                     tlast;
  logic [TID_WIDTH_P-1:0]   tid;
  logic [TDEST_WIDTH_P-1:0] tdest;
  logic [TUSER_WIDTH_P-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pipe_reg.sv
// Single valid/ready register slice; an empty slot (bubble) always accepts new data.
module axis_pipe_reg #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 load_c;

  // Slot may load when empty or when its current beat leaves this cycle
  always_comb begin
    load_c  = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_c) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  // Slot state; reset flushes the beat and clears the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = load_c;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/axis_rgb2gray.sv
// RGB888 to 8-bit luma AXI-Stream stage: products, rounded sum, luma, each in its own slice.
module axis_rgb2gray
  import image_proc_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH_P = 32,
  parameter int unsigned TID_WIDTH_P   = 1,
  parameter int unsigned TDEST_WIDTH_P = 1,
  parameter int unsigned TUSER_WIDTH_P = 1,
  parameter int unsigned COEF_R_P      = LUMA_COEF_R,
  parameter int unsigned COEF_G_P      = LUMA_COEF_G,
  parameter int unsigned COEF_B_P      = LUMA_COEF_B,
  parameter bit          REPLICATE_P   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  axis_rgb2gray_if.slave  s_axis,
  axis_rgb2gray_if.master m_axis
);

  localparam int unsigned KEEP_W = TDATA_WIDTH_P / 8;
  localparam int unsigned SB_W   = 2 * KEEP_W + 1 + TID_WIDTH_P + TDEST_WIDTH_P + TUSER_WIDTH_P;
  localparam int unsigned S1_W   = 3 * PROD_W + SB_W;
  localparam int unsigned S2_W   = PROD_W + SB_W;
  localparam int unsigned S3_W   = LUMA_W + SB_W;

  if (TDATA_WIDTH_P < 24 || (TDATA_WIDTH_P % 8) != 0) begin : g_bad_width
    $error("axis_rgb2gray: TDATA_WIDTH_P must be >= 24 and a multiple of 8");
  end
  if (COEF_R_P + COEF_G_P + COEF_B_P != 256) begin : g_bad_coef
    $error("axis_rgb2gray: luma weights must sum to 256");
  end

  rgb888_t           px;
  logic [SB_W-1:0]   sb_in, sb1, sb2, sb3;
  logic [S1_W-1:0]   s1_in, s1_out;
  logic [S2_W-1:0]   s2_in, s2_out;
  logic [S3_W-1:0]   s3_in, s3_out;
  logic              s1_valid, s2_valid, s3_valid;
  logic              s2_ready, s3_ready;
  logic [PROD_W-1:0] pr_q, pg_q, pb_q, sum_d, sum_q;
  logic [LUMA_W-1:0] luma_d, luma_q;
  logic              unused_bits;

  // Unpack the input pixel and sideband
  assign px    = s_axis.tdata[23:0];
  assign sb_in = {s_axis.tkeep, s_axis.tstrb, s_axis.tlast, s_axis.tid, s_axis.tdest, s_axis.tuser};
  assign s1_in = {luma_mul(px.r, COEF_R_P), luma_mul(px.g, COEF_G_P), luma_mul(px.b, COEF_B_P), sb_in};

  axis_pipe_reg #(.PAYLOAD_W(S1_W)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s_axis.tvalid), .in_ready_o(s_axis.tready), .in_data_i(s1_in),
    .out_valid_o(s1_valid), .out_ready_i(s2_ready), .out_data_o(s1_out)
  );

  // Rounded weighted sum; bounded by 65408 so 16 bits never overflow
  assign {pr_q, pg_q, pb_q, sb1} = s1_out;
  assign sum_d = pr_q + pg_q + pb_q + PROD_W'(LUMA_ROUND);
  assign s2_in = {sum_d, sb1};

  axis_pipe_reg #(.PAYLOAD_W(S2_W)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s1_valid), .in_ready_o(s2_ready), .in_data_i(s2_in),
    .out_valid_o(s2_valid), .out_ready_i(s3_ready), .out_data_o(s2_out)
  );

  // Drop the fraction; the +128 already made this round-half-up
  assign {sum_q, sb2} = s2_out;
  assign luma_d = sum_q[15:8];
  assign s3_in  = {luma_d, sb2};

  axis_pipe_reg #(.PAYLOAD_W(S3_W)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s2_valid), .in_ready_o(s3_ready), .in_data_i(s3_in),
    .out_valid_o(s3_valid), .out_ready_i(m_axis.tready), .out_data_o(s3_out)
  );

  // Output packing: luma replicated into all three colour bytes or only the low byte
  assign {luma_q, sb3}  = s3_out;
  assign m_axis.tvalid  = s3_valid;
  assign m_axis.tdata   = REPLICATE_P ? TDATA_WIDTH_P'({luma_q, luma_q, luma_q})
                                      : TDATA_WIDTH_P'(luma_q);
  assign {m_axis.tkeep, m_axis.tstrb, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = sb3;

  // Fraction bits and the pixel bits above [23:0] carry no information here
  assign unused_bits = ^{sum_q[7:0], s_axis.tdata};

endmodule

// File: tb/tb_axis_rgb2gray.sv
// Directed and random checks of axis_rgb2gray with REPLICATE_P=1 and default weights.
module tb_axis_rgb2gray;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } beat_t;

  localparam int unsigned N_RAND = 10000;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  bit    rnd_done = 1'b0;
  beat_t obs_q[$];
  beat_t exp_q[$];

  axis_rgb2gray_if #(.TDATA_WIDTH_P(32), .TID_WIDTH_P(1), .TDEST_WIDTH_P(1), .TUSER_WIDTH_P(1)) s_if ();
  axis_rgb2gray_if #(.TDATA_WIDTH_P(32), .TID_WIDTH_P(1), .TDEST_WIDTH_P(1), .TUSER_WIDTH_P(1)) m_if ();

  axis_rgb2gray #(
    .TDATA_WIDTH_P(32), .TID_WIDTH_P(1), .TDEST_WIDTH_P(1), .TUSER_WIDTH_P(1),
    .COEF_R_P(77), .COEF_G_P(150), .COEF_B_P(29), .REPLICATE_P(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                               input logic l, input logic i, input logic de, input logic u);
    beat_t b;
    b = {d, k, s, l, i, de, u};
    return b;
  endfunction

  // Reference luma: (77R + 150G + 29B + 128) >> 8, copied into the three low bytes
  function automatic beat_t ref_beat(input beat_t b);
    beat_t       r;
    int unsigned l;
    logic [7:0]  l8;
    r  = b;
    l  = (32'd77 * 32'(b.data[23:16]) + 32'd150 * 32'(b.data[15:8]) + 32'd29 * 32'(b.data[7:0]) + 32'd128) >> 8;
    l8 = 8'(l);
    r.data = {8'h00, l8, l8, l8};
    return r;
  endfunction

  function automatic beat_t s_beat();
    return {s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser};
  endfunction

  function automatic beat_t m_beat();
    return {m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
  endfunction

  // Record both handshakes on every clock edge
  always @(posedge clk) begin
    if (rst_n) begin
      if (s_if.tvalid && s_if.tready) exp_q.push_back(ref_beat(s_beat()));
      if (m_if.tvalid && m_if.tready) obs_q.push_back(m_beat());
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input beat_t b);
    logic rdy;
    bit   done;
    done = 1'b0;
    s_if.tvalid = 1'b1;
    {s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = b;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    if (!done) check("send_handshake", 64'(done), 64'd1);
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] pix_in [5];
    logic [31:0] pix_exp[5];
    beat_t       b;
    int          n;

    pix_in[0] = 32'h00FF0000; pix_exp[0] = 32'h004D4D4D;
    pix_in[1] = 32'h0000FF00; pix_exp[1] = 32'h00959595;
    pix_in[2] = 32'h000000FF; pix_exp[2] = 32'h001D1D1D;
    pix_in[3] = 32'h00FFFFFF; pix_exp[3] = 32'h00FFFFFF;
    pix_in[4] = 32'h00000000; pix_exp[4] = 32'h00000000;

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
    s_if.tlast = 1'b0; s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
    m_if.tready = 1'b0;

    // ---- reset ----
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_payload", 64'(m_beat()), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd1);

    // ---- latency and known pixels ----
    m_if.tready = 1'b1;
    obs_q.delete();
    send(mk(pix_in[0], 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
    check("lat_clk1_tvalid", 64'(m_if.tvalid), 64'd0);
    tick();
    check("lat_clk2_tvalid", 64'(m_if.tvalid), 64'd0);
    tick();
    check("lat_clk3_tvalid", 64'(m_if.tvalid), 64'd1);
    check("lat_clk3_tdata", 64'(m_if.tdata), 64'(pix_exp[0]));
    for (int i = 1; i < 5; i++) send(mk(pix_in[i], 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (5) tick();
    check("pix_count", 64'(obs_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check("pix_data", 64'(obs_q[i].data), 64'(pix_exp[i]));

    // ---- backpressure: 8 gray beats, output stalled mid-stream ----
    obs_q.delete();
    fork
      begin
        for (int i = 1; i <= 8; i++) send(mk(32'(i) * 32'h00010101, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      begin
        repeat (4) tick();
        m_if.tready = 1'b0;
        #1;
        check("bp_full_s_tready", 64'(s_if.tready), 64'd0);
        for (int c = 0; c < 6; c++) begin
          tick();
          check("bp_stall_tvalid", 64'(m_if.tvalid), 64'd1);
          check("bp_stall_tdata", 64'(m_if.tdata), 64'h00020202);
          check("bp_stall_s_tready", 64'(s_if.tready), 64'd0);
        end
        m_if.tready = 1'b1;
        #1;
        check("bp_release_s_tready", 64'(s_if.tready), 64'd1);
      end
    join
    repeat (6) tick();
    check("bp_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check("bp_order", 64'(obs_q[i].data), 64'(32'(i + 1) * 32'h00010101));

    // ---- 4x2 frame with sideband and random input gaps ----
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(mk(32'(i * 16 + 5) * 32'h00010101, 4'hF, 4'h7, (i == 3 || i == 7), 1'b1, 1'b1, (i == 0)));
    end
    repeat (6) tick();
    check("frame_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check("frame_beat", 64'(obs_q[i]),
            64'(mk(32'(i * 16 + 5) * 32'h00010101, 4'hF, 4'h7, (i == 3 || i == 7), 1'b1, 1'b1, (i == 0))));

    // ---- reset with three beats in flight ----
    m_if.tready = 1'b0;
    obs_q.delete();
    send(mk(32'h00102030, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    send(mk(32'h00405060, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(32'h00708090, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0));
    check("mrst_held_tvalid", 64'(m_if.tvalid), 64'd1);
    check("mrst_held_s_tready", 64'(s_if.tready), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_async_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mrst_async_tdata", 64'(m_if.tdata), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    exp_q.delete();
    repeat (8) tick();
    check("mrst_no_output", 64'(obs_q.size()), 64'd0);
    check("mrst_s_tready", 64'(s_if.tready), 64'd1);

    // ---- random traffic against the reference formula ----
    obs_q.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < int'(N_RAND); i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          b = mk($urandom, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          send(b);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          m_if.tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_if.tready = 1'b1;
    for (int k = 0; k < 200 && obs_q.size() < int'(N_RAND); k++) tick();
    check("rand_obs_count", 64'(obs_q.size()), 64'(N_RAND));
    check("rand_exp_count", 64'(exp_q.size()), 64'(N_RAND));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("rand_beat", 64'(obs_q[i]), 64'(exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
